// File: rtl/filter_loader.sv
// Filter loader: fetches a KxK filter from weight RAM one word per cycle, then
// hands the assembled array to the filter buffer via the buf_read/buf_finish handshake.
module filter_loader #(
    parameter int K      = 5,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic [K*K*DATA_W-1:0] buf_filter_o,
    output logic                  buf_read_o,
    input  logic                  buf_finish_i
);

    localparam int N  = K * K;
    localparam int KW = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, HANDOFF, RELEASE, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [KW-1:0]       k_q, k_d;
    logic [KW-1:0]       capIdx_q, capIdx_d;
    logic                capVld_q, capVld_d;
    logic                armed_q, armed_d;
    logic [N*DATA_W-1:0] filter_q, filter_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            base_q   <= '0;
            k_q      <= '0;
            capIdx_q <= '0;
            capVld_q <= 1'b0;
            armed_q  <= 1'b0;
            filter_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            k_q      <= k_d;
            capIdx_q <= capIdx_d;
            capVld_q <= capVld_d;
            armed_q  <= armed_d;
            filter_q <= filter_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        capIdx_d    = capIdx_q;
        capVld_d    = 1'b0;
        armed_d     = armed_q;
        filter_d    = filter_q;
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_addr_o  = '0;
        buf_read_o  = 1'b0;

        // RAM data arrives one cycle after its issue; land it at the issued index.
        if (capVld_q) begin
            filter_d[int'(capIdx_q) * DATA_W +: DATA_W] = mem_rdata_i;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = base_q + ADDR_W'(k_q);
                capVld_d    = 1'b1;
                capIdx_d    = k_q;
                if (k_q == KW'(N - 1)) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                // Only a finish that rises while buf_read is high may complete the handoff.
                armed_d = ~buf_finish_i;
                state_d = HANDOFF;
            end
            HANDOFF: begin
                buf_read_o = 1'b1;
                if (buf_finish_i && armed_q) begin
                    state_d = RELEASE;
                end else if (!buf_finish_i) begin
                    armed_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!buf_finish_i) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign buf_filter_o = filter_q;

endmodule

// File: tb/tb_filter_loader.sv
// Directed self-checking bench for filter_loader: RAM model, filter-buffer model,
// and one task per scenario with inline comparisons against hand-derived values.
module tb_filter_loader;

    localparam int K  = 5;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int N  = K * K;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic            busy, done, mem_rd_en, buf_read;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic [N*DW-1:0] buf_filter;
    logic            buf_finish;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [DW-1:0] ram [0:65535];
    logic          autoBuf = 1'b1;
    logic          autoFinish = 1'b0;
    logic          manualFinish = 1'b0;
    int            rdCnt = 0;

    int              edgeCnt = 0;
    int              e0 = 0;
    logic [AW-1:0]   addrQ [$];
    int              doneCnt = 0;
    int              readRise = -1;
    int              firstRd = -1;
    logic            prevRead = 1'b0;
    logic [N*DW-1:0] snap, snapEnd;
    logic [DW-1:0]   expW [N];

    filter_loader #(.K(K), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .busy_o       (busy),
        .done_o       (done),
        .mem_rd_en_o  (mem_rd_en),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata),
        .buf_filter_o (buf_filter),
        .buf_read_o   (buf_read),
        .buf_finish_i (buf_finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    always @(posedge clk) mem_rdata <= ram[mem_addr];

    // Buffer model: finish two cycles after buf_read rises, drops one cycle after it falls.
    always @(posedge clk) begin
        if (!rst_n) begin
            rdCnt      <= 0;
            autoFinish <= 1'b0;
        end else if (buf_read) begin
            rdCnt <= rdCnt + 1;
            if (rdCnt >= 1) autoFinish <= 1'b1;
        end else begin
            rdCnt      <= 0;
            autoFinish <= 1'b0;
        end
    end

    assign buf_finish = autoBuf ? autoFinish : manualFinish;

    always @(negedge clk) begin
        if (mem_rd_en) begin
            addrQ.push_back(mem_addr);
            if (firstRd < 0) firstRd = edgeCnt;
        end
        if (done) doneCnt++;
        if (buf_read && !prevRead) begin
            readRise = edgeCnt;
            snap     = buf_filter;
        end
        if (buf_read) snapEnd = buf_filter;
        prevRead = buf_read;
    end

    task automatic clearMon();
        addrQ.delete();
        doneCnt  = 0;
        readRise = -1;
        firstRd  = -1;
    endtask

    task automatic startLoad(input logic [AW-1:0] b);
        @(negedge clk);
        base_addr = b;
        start     = 1'b1;
        e0        = edgeCnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            testsRun++;
            if ({busy, done, mem_rd_en, buf_read} !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_rd_en, buf_read});
            end
            testsRun++;
            if (mem_addr !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_addr: got %h expected 0000", mem_addr);
            end
            testsRun++;
            if (buf_filter !== '0) begin
                testsFailed++;
                $display("[TB] FAIL reset_filter: got nonzero expected all zero");
            end
        end
    endtask

    task automatic test_basic_load();
        bit ok;
        for (int i = 0; i < N; i++) begin
            ram[16'h0100 + i] = 16'(i * 3 - 20);
            expW[i] = 16'(i * 3 - 20);
        end
        clearMon();
        startLoad(16'h0100);
        waitDone(ok);
        testsRun++;
        if (!ok) begin
            testsFailed++;
            $display("[TB] FAIL basic_timeout: got busy=%b expected 0", busy);
        end
        testsRun++;
        if (firstRd - e0 !== 1) begin
            testsFailed++;
            $display("[TB] FAIL basic_first_rd: got cycle %0d expected 1", firstRd - e0);
        end
        testsRun++;
        if (addrQ.size() !== N) begin
            testsFailed++;
            $display("[TB] FAIL basic_addr_count: got %0d expected %0d", addrQ.size(), N);
        end
        for (int i = 0; i < N && i < addrQ.size(); i++) begin
            testsRun++;
            if (addrQ[i] !== 16'(16'h0100 + i)) begin
                testsFailed++;
                $display("[TB] FAIL basic_addr[%0d]: got %h expected %h", i, addrQ[i], 16'(16'h0100 + i));
            end
        end
        testsRun++;
        if (readRise - e0 !== 27) begin
            testsFailed++;
            $display("[TB] FAIL basic_read_cycle: got %0d expected 27", readRise - e0);
        end
        for (int i = 0; i < N; i++) begin
            testsRun++;
            if (snap[i*DW +: DW] !== expW[i]) begin
                testsFailed++;
                $display("[TB] FAIL basic_word[%0d]: got %0d expected %0d", i,
                         $signed(snap[i*DW +: DW]), $signed(expW[i]));
            end
        end
        testsRun++;
        if ($signed(snap[24*DW +: DW]) !== 16'sd52 || $signed(snap[0 +: DW]) !== -16'sd20) begin
            testsFailed++;
            $display("[TB] FAIL basic_corners: got [4][4]=%0d [0][0]=%0d expected 52 -20",
                     $signed(snap[24*DW +: DW]), $signed(snap[0 +: DW]));
        end
        testsRun++;
        if (doneCnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCnt);
        end
        testsRun++;
        if (buf_filter !== snap) begin
            testsFailed++;
            $display("[TB] FAIL basic_hold: got changed filter expected held value");
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        for (int i = 0; i < N; i++) begin
            ram[16'h0200 + i] = 16'(500 - i * 11);
            expW[i] = 16'(500 - i * 11);
        end
        clearMon();
        startLoad(16'h0200);
        repeat (8) @(negedge clk);
        base_addr = 16'h0500;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !buf_read; i++) @(negedge clk);
        base_addr = 16'h0600;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(ok);
        repeat (3) @(negedge clk);
        testsRun++;
        if (!ok || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ign_idle: got busy=%b ok=%0d expected idle", busy, ok);
        end
        testsRun++;
        if (addrQ.size() !== N) begin
            testsFailed++;
            $display("[TB] FAIL ign_addr_count: got %0d expected %0d", addrQ.size(), N);
        end
        for (int i = 0; i < N && i < addrQ.size(); i++) begin
            testsRun++;
            if (addrQ[i] !== 16'(16'h0200 + i)) begin
                testsFailed++;
                $display("[TB] FAIL ign_addr[%0d]: got %h expected %h", i, addrQ[i], 16'(16'h0200 + i));
            end
        end
        testsRun++;
        if (doneCnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL ign_done_count: got %0d expected 1", doneCnt);
        end
        for (int i = 0; i < N; i++) begin
            testsRun++;
            if (snap[i*DW +: DW] !== expW[i]) begin
                testsFailed++;
                $display("[TB] FAIL ign_word[%0d]: got %0d expected %0d", i,
                         $signed(snap[i*DW +: DW]), $signed(expW[i]));
            end
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        for (int i = 0; i < N; i++) begin
            ram[16'(16'hFFF0 + i)] = 16'(i * 1000 - 7);
            expW[i] = 16'(i * 1000 - 7);
        end
        clearMon();
        startLoad(16'hFFF0);
        waitDone(ok);
        testsRun++;
        if (!ok || addrQ.size() !== N) begin
            testsFailed++;
            $display("[TB] FAIL wrap_count: got %0d ok=%0d expected %0d", addrQ.size(), ok, N);
        end
        for (int i = 0; i < N && i < addrQ.size(); i++) begin
            testsRun++;
            if (addrQ[i] !== 16'(16'hFFF0 + i)) begin
                testsFailed++;
                $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, addrQ[i], 16'(16'hFFF0 + i));
            end
        end
        testsRun++;
        if (snap[16*DW +: DW] !== expW[16] || snap[24*DW +: DW] !== expW[24]) begin
            testsFailed++;
            $display("[TB] FAIL wrap_words: got %h %h expected %h %h",
                     snap[16*DW +: DW], snap[24*DW +: DW], expW[16], expW[24]);
        end
    endtask

    task automatic test_finish_held();
        bit ok;
        bit seen = 1'b0;
        for (int i = 0; i < N; i++) ram[16'h0300 + i] = 16'(i);
        clearMon();
        autoBuf      = 1'b0;
        manualFinish = 1'b1;
        startLoad(16'h0300);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (buf_read) begin
                seen = 1'b1;
                break;
            end
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("[TB] FAIL held_read_seen: got buf_read=0 expected 1");
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            testsRun++;
            if (buf_read !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL held_stay_hi[%0d]: got %b expected 1", c, buf_read);
            end
        end
        manualFinish = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            testsRun++;
            if (buf_read !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL held_stay_lo[%0d]: got %b expected 1", c, buf_read);
            end
        end
        manualFinish = 1'b1;
        @(negedge clk);
        testsRun++;
        if (buf_read !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL held_release: got read=%b busy=%b expected 0 1", buf_read, busy);
        end
        manualFinish = 1'b0;
        waitDone(ok);
        testsRun++;
        if (!ok || doneCnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL held_done: got %0d ok=%0d expected 1", doneCnt, ok);
        end
        autoBuf = 1'b1;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        for (int i = 0; i < N; i++) expW[i] = 16'(i * 3 - 20);
        clearMon();
        startLoad(16'h0100);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({busy, done, mem_rd_en, buf_read} !== 4'b0000 || mem_addr !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_ctrl: got %b addr=%h expected 0000 addr=0000",
                     {busy, done, mem_rd_en, buf_read}, mem_addr);
        end
        testsRun++;
        if (buf_filter !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_filter: got nonzero expected all zero");
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (busy !== 1'b0 || doneCnt !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_no_resume: got busy=%b done=%0d expected 0 0", busy, doneCnt);
        end
        clearMon();
        startLoad(16'h0100);
        waitDone(ok);
        testsRun++;
        if (!ok || doneCnt !== 1 || addrQ.size() !== N) begin
            testsFailed++;
            $display("[TB] FAIL midrst_reload: got done=%0d addrs=%0d expected 1 %0d", doneCnt, addrQ.size(), N);
        end
        for (int i = 0; i < N; i++) begin
            testsRun++;
            if (snap[i*DW +: DW] !== expW[i]) begin
                testsFailed++;
                $display("[TB] FAIL midrst_word[%0d]: got %0d expected %0d", i,
                         $signed(snap[i*DW +: DW]), $signed(expW[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [AW-1:0] b;
        for (int t = 0; t < 300; t++) begin
            b = 16'($urandom_range(0, 65535));
            for (int i = 0; i < N; i++) begin
                expW[i] = 16'($urandom % 100);
                ram[16'(b + i)] = expW[i];
            end
            clearMon();
            startLoad(b);
            waitDone(ok);
            testsRun++;
            if (!ok || doneCnt !== 1) begin
                testsFailed++;
                $display("[TB] FAIL b2b_done[%0d]: got %0d ok=%0d expected 1", t, doneCnt, ok);
            end
            for (int i = 0; i < N; i++) begin
                testsRun++;
                if (snap[i*DW +: DW] !== expW[i] || snapEnd[i*DW +: DW] !== expW[i]) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_word[%0d][%0d]: got %0d/%0d expected %0d", t, i,
                             snap[i*DW +: DW], snapEnd[i*DW +: DW], expW[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        test_reset();
        test_basic_load();
        test_ignored_start();
        test_addr_wrap();
        test_finish_held();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
